// File: rtl/pc_gen_multi_pkg.sv
// Shared fetch-side types: redirect sources with their priority, FSM states and the reset vector.
package cdim_fetch_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        FL   = 2'd1,
        BR   = 2'd2,
        EXC  = 2'd3
    } redir_src_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } pc_state_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'hbfc00000;

    // The encoding doubles as the priority: EXC > BR > FL > NONE.
    function automatic logic [1:0] redir_prio(input redir_src_e src);
        return src;
    endfunction

endpackage

// File: rtl/pc_gen_multi_if.sv
// Fetch-PC generator bus: redirect requests and fetch handshake in, PC/epoch status out.
interface pc_gen_multi_if #(
    parameter int FETCH_WIDTH = 2,
    parameter int EPOCH_W     = 2
);
    logic                   pc_en;
    logic [FETCH_WIDTH-1:0] inst_ok;
    logic                   fifo_full;
    logic                   except_en;
    logic [31:0]            except_addr;
    logic                   branch_en;
    logic                   branch_taken;
    logic [31:0]            branch_addr;
    logic                   flush_all;
    logic [31:0]            flush_all_addr;
    logic [31:0]            pc_next;
    logic [31:0]            pc_curr;
    logic [EPOCH_W-1:0]     epoch;
    logic                   redir_pending;
    logic                   fetch_adel;

    modport master (
        output pc_en, inst_ok, fifo_full,
        output except_en, except_addr,
        output branch_en, branch_taken, branch_addr,
        output flush_all, flush_all_addr,
        input  pc_next, pc_curr, epoch, redir_pending, fetch_adel
    );

    modport slave (
        input  pc_en, inst_ok, fifo_full,
        input  except_en, except_addr,
        input  branch_en, branch_taken, branch_addr,
        input  flush_all, flush_all_addr,
        output pc_next, pc_curr, epoch, redir_pending, fetch_adel
    );
endinterface

// File: rtl/pc_gen_multi_adv_cnt.sv
// Leading-ones counter: number of contiguous accepted fetch slots starting from the oldest (bit 0).
module pc_adv_cnt #(
    parameter int FETCH_WIDTH = 2
) (
    input  logic [FETCH_WIDTH-1:0]         inst_ok,
    output logic [$clog2(FETCH_WIDTH+1)-1:0] adv_cnt
);
    localparam int CNT_W = $clog2(FETCH_WIDTH + 1);

    logic run;

    always_comb begin
        adv_cnt = '0;
        run     = 1'b1;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (run && inst_ok[i]) begin
                adv_cnt = CNT_W'(i + 1);
            end else begin
                run = 1'b0;
            end
        end
    end
endmodule

// File: rtl/pc_gen_multi.sv
// N-wide fetch-PC generator with prioritised, bufferable, epoch-tagged redirects.
// Optional misaligned-fetch detection is built when PC_ADEL_CHECK_EN is defined.
module pc_gen_multi
    import cdim_fetch_pkg::*;
#(
    parameter int          FETCH_WIDTH = 2,
    parameter logic [31:0] RESET_PC    = PC_RESET_DEFAULT,
    parameter int          EPOCH_W     = 2
) (
    input  logic          clk,
    input  logic          resetn,
    pc_gen_multi_if.slave bus
);
    localparam int CNT_W = $clog2(FETCH_WIDTH + 1);

    logic [CNT_W-1:0]   adv_cnt;
    logic [31:0]        adv_bytes;
    logic [31:0]        pc_q;
    logic [31:0]        pc_next;
    logic [EPOCH_W-1:0] epoch_q;
    logic [31:0]        pend_addr_q;
    redir_src_e         pend_src_q;
    pc_state_e          state_q;
    pc_state_e          state_d;
    redir_src_e         fresh_src;
    logic [31:0]        fresh_addr;
    redir_src_e         win_src;
    logic [31:0]        win_addr;
    logic               capture;
    logic               redir_applied;
    logic               seq_hold;

    pc_adv_cnt #(.FETCH_WIDTH(FETCH_WIDTH)) u_adv_cnt (
        .inst_ok (bus.inst_ok),
        .adv_cnt (adv_cnt)
    );

    assign adv_bytes = 32'(adv_cnt) << 2;

    always_comb begin
        fresh_src  = NONE;
        fresh_addr = '0;
        if (bus.except_en) begin
            fresh_src  = EXC;
            fresh_addr = bus.except_addr;
        end else if (bus.branch_en && bus.branch_taken) begin
            fresh_src  = BR;
            fresh_addr = bus.branch_addr;
        end else if (bus.flush_all) begin
            fresh_src  = FL;
            fresh_addr = bus.flush_all_addr;
        end
    end

    // A fresh redirect beats a buffered one of equal priority.
    always_comb begin
        win_src  = NONE;
        win_addr = '0;
        if (fresh_src != NONE && redir_prio(fresh_src) >= redir_prio(pend_src_q)) begin
            win_src  = fresh_src;
            win_addr = fresh_addr;
        end else if (pend_src_q != NONE) begin
            win_src  = pend_src_q;
            win_addr = pend_addr_q;
        end
    end

    assign redir_applied = bus.pc_en && (win_src != NONE);

`ifdef PC_ADEL_CHECK_EN
    logic adel_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adel_q <= 1'b0;
        end else if (bus.pc_en) begin
            adel_q <= |pc_next[1:0];
        end
    end

    // Freeze on the faulting address so the handler sees a stable BadVAddr.
    assign seq_hold       = bus.fifo_full | adel_q;
    assign bus.fetch_adel = adel_q;
`else
    assign seq_hold       = bus.fifo_full;
    assign bus.fetch_adel = 1'b0;
`endif

    always_comb begin
        pc_next = pc_q;
        if (!resetn) begin
            pc_next = RESET_PC;
        end else if (win_src != NONE) begin
            pc_next = win_addr;
        end else if (seq_hold) begin
            pc_next = pc_q;
        end else begin
            pc_next = pc_q + adv_bytes;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (bus.pc_en) begin
            state_d = ST_RUN;
        end else if (fresh_src != NONE) begin
            state_d = ST_HOLD;
            capture = redir_prio(fresh_src) >= redir_prio(pend_src_q);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q        <= RESET_PC;
            epoch_q     <= '0;
            pend_addr_q <= '0;
            pend_src_q  <= NONE;
        end else begin
            if (bus.pc_en) begin
                pc_q <= pc_next;
            end
            if (redir_applied) begin
                epoch_q     <= epoch_q + EPOCH_W'(1);
                pend_addr_q <= '0;
                pend_src_q  <= NONE;
            end else if (capture) begin
                pend_addr_q <= fresh_addr;
                pend_src_q  <= fresh_src;
            end
        end
    end

    assign bus.pc_next       = pc_next;
    assign bus.pc_curr       = pc_q;
    assign bus.epoch         = epoch_q;
    assign bus.redir_pending = (state_q == ST_HOLD);
endmodule

// File: tb/tb_pc_gen_multi.sv
// Directed bench for pc_gen_multi (FETCH_WIDTH=4, EPOCH_W=2); honours PC_ADEL_CHECK_EN.
module tb_pc_gen_multi;
    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_bad;

    pc_gen_multi_if #(.FETCH_WIDTH(4), .EPOCH_W(2)) bus ();

    pc_gen_multi #(
        .FETCH_WIDTH (4),
        .RESET_PC    (32'hbfc00000),
        .EPOCH_W     (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redir();
        bus.except_en    = 1'b0;
        bus.branch_en    = 1'b0;
        bus.branch_taken = 1'b0;
        bus.flush_all    = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        resetn             = 1'b1;
        bus.pc_en          = 1'b1;
        bus.inst_ok        = 4'b1111;
        bus.fifo_full      = 1'b0;
        bus.except_addr    = '0;
        bus.branch_addr    = '0;
        bus.flush_all_addr = '0;
        clear_redir();
        #1 resetn = 1'b0;
        #2;
        check_val("rst_pc_curr", bus.pc_curr, 32'hbfc00000);
        check_val("rst_pc_next", bus.pc_next, 32'hbfc00000);
        check_val("rst_epoch", 32'(bus.epoch), 32'd0);
        check_val("rst_pending", 32'(bus.redir_pending), 32'd0);
        check_val("rst_adel", 32'(bus.fetch_adel), 32'd0);
        step();
        step();
        check_val("rst_hold_pc", bus.pc_curr, 32'hbfc00000);
        resetn = 1'b1;
        #1;

        // Test 1: full-width sequential advance
        check_val("t1_pc0", bus.pc_curr, 32'hbfc00000);
        check_val("t1_next0", bus.pc_next, 32'hbfc00010);
        step();
        check_val("t1_pc1", bus.pc_curr, 32'hbfc00010);
        step();
        check_val("t1_pc2", bus.pc_curr, 32'hbfc00020);
        check_val("t1_epoch", 32'(bus.epoch), 32'd0);

        // Test 2: flush back to the vector, then partial / non-contiguous slots
        bus.flush_all = 1'b1; bus.flush_all_addr = 32'hbfc00000;
        step();
        clear_redir();
        check_val("t2_flush_pc", bus.pc_curr, 32'hbfc00000);
        check_val("t2_flush_epoch", 32'(bus.epoch), 32'd1);
        bus.inst_ok = 4'b1011;
        step();
        check_val("t2_pc_1011", bus.pc_curr, 32'hbfc00008);
        bus.inst_ok = 4'b0110;
        step();
        check_val("t2_pc_0110", bus.pc_curr, 32'hbfc00008);
        bus.inst_ok = 4'b1111; bus.fifo_full = 1'b1;
        step();
        check_val("t2_fifo_full", bus.pc_curr, 32'hbfc00008);
        bus.fifo_full = 1'b0;

        // Test 3: branch while stalled is buffered
        bus.pc_en = 1'b0;
        bus.branch_en = 1'b1; bus.branch_taken = 1'b1; bus.branch_addr = 32'h80001000;
        step();
        clear_redir();
        check_val("t3_pending", 32'(bus.redir_pending), 32'd1);
        check_val("t3_held", bus.pc_curr, 32'hbfc00008);
        step();
        step();
        check_val("t3_still_pending", 32'(bus.redir_pending), 32'd1);
        check_val("t3_pend_next", bus.pc_next, 32'h80001000);
        check_val("t3_epoch_hold", 32'(bus.epoch), 32'd1);
        bus.pc_en = 1'b1;
        step();
        check_val("t3_pc", bus.pc_curr, 32'h80001000);
        check_val("t3_epoch", 32'(bus.epoch), 32'd2);
        check_val("t3_pending_clr", 32'(bus.redir_pending), 32'd0);
        bus.branch_en = 1'b1; bus.branch_taken = 1'b0; bus.branch_addr = 32'h80009000;
        step();
        clear_redir();
        check_val("t3_not_taken_pc", bus.pc_curr, 32'h80001010);
        check_val("t3_not_taken_ep", 32'(bus.epoch), 32'd2);

        // Test 4: exception overwrites pending branch, later flush is dropped
        bus.pc_en = 1'b0;
        bus.branch_en = 1'b1; bus.branch_taken = 1'b1; bus.branch_addr = 32'h80002000;
        step();
        clear_redir();
        bus.except_en = 1'b1; bus.except_addr = 32'hbfc00380;
        step();
        clear_redir();
        check_val("t4_exc_over", bus.pc_next, 32'hbfc00380);
        bus.flush_all = 1'b1; bus.flush_all_addr = 32'h90000000;
        step();
        clear_redir();
        check_val("t4_fl_dropped", bus.pc_next, 32'hbfc00380);
        check_val("t4_held", bus.pc_curr, 32'h80001010);
        bus.pc_en = 1'b1;
        step();
        check_val("t4_pc", bus.pc_curr, 32'hbfc00380);
        check_val("t4_epoch", 32'(bus.epoch), 32'd3);
        check_val("t4_pending_clr", 32'(bus.redir_pending), 32'd0);

        // Test 5: simultaneous sources, exception wins, epoch wraps 3 -> 0
        bus.except_en = 1'b1; bus.except_addr = 32'hbfc00200;
        bus.branch_en = 1'b1; bus.branch_taken = 1'b1; bus.branch_addr = 32'h80003000;
        bus.flush_all = 1'b1; bus.flush_all_addr = 32'h90000000;
        step();
        check_val("t5_pc_wrap", bus.pc_curr, 32'hbfc00200);
        check_val("t5_epoch_wrap", 32'(bus.epoch), 32'd0);
        bus.except_addr = 32'hbfc00300;
        step();
        clear_redir();
        check_val("t5_pc_again", bus.pc_curr, 32'hbfc00300);
        check_val("t5_epoch_once", 32'(bus.epoch), 32'd1);

        // Equal-priority tie: fresh flush beats pending flush
        bus.pc_en = 1'b0;
        bus.flush_all = 1'b1; bus.flush_all_addr = 32'h80004000;
        step();
        bus.pc_en = 1'b1; bus.flush_all_addr = 32'h80005000;
        step();
        clear_redir();
        check_val("tie_pc", bus.pc_curr, 32'h80005000);
        check_val("tie_epoch", 32'(bus.epoch), 32'd2);

        // Test 6: misaligned redirect target
        bus.flush_all = 1'b1; bus.flush_all_addr = 32'h80000002;
        step();
        clear_redir();
        check_val("t6_pc", bus.pc_curr, 32'h80000002);
        check_val("t6_epoch", 32'(bus.epoch), 32'd3);
`ifdef PC_ADEL_CHECK_EN
        check_val("t6_adel_set", 32'(bus.fetch_adel), 32'd1);
        step();
        check_val("t6_pc_frozen", bus.pc_curr, 32'h80000002);
`else
        check_val("t6_adel_off", 32'(bus.fetch_adel), 32'd0);
        step();
        check_val("t6_pc_adv", bus.pc_curr, 32'h80000012);
`endif
        bus.except_en = 1'b1; bus.except_addr = 32'hbfc00380;
        step();
        clear_redir();
        check_val("t6_exc_pc", bus.pc_curr, 32'hbfc00380);
        check_val("t6_adel_clr", 32'(bus.fetch_adel), 32'd0);
        check_val("t6_epoch_wrap", 32'(bus.epoch), 32'd0);

        // Asynchronous reset mid-run, no clock edge needed
        step();
        #2 resetn = 1'b0;
        #1;
        check_val("arst_pc", bus.pc_curr, 32'hbfc00000);
        check_val("arst_next", bus.pc_next, 32'hbfc00000);
        check_val("arst_pending", 32'(bus.redir_pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
